// File: rtl/prime_job_sched_if.sv
// Job request, engine and response signals of the prime-sum job scheduler.
// The scheduler uses the slave modport; requesters/engine/consumer use master.
interface prime_job_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_n;
    logic              eng_start;
    logic [W-1:0]      eng_a;
    logic [W-1:0]      eng_n;
    logic              eng_done;
    logic [W-1:0]      eng_sum;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_a, req_n, eng_done, eng_sum, rsp_ready,
        input  req_ready, eng_start, eng_a, eng_n, rsp_valid, rsp_id, rsp_sum, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_a, req_n, eng_done, eng_sum, rsp_ready,
        output req_ready, eng_start, eng_a, eng_n, rsp_valid, rsp_id, rsp_sum, rsp_err, busy
    );
endinterface

// File: rtl/prime_job_sched.sv
// Round-robin scheduler sharing one prime-sum engine between NREQ requesters,
// with an engine timeout that turns a hung job into an error response.
module prime_job_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    prime_job_sched_if.slave  bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   sum;
        logic           err;
    } rsp_t;

    state_t         r_state, w_state_nxt;
    logic [IDW-1:0] r_rr_ptr, w_rr_nxt;
    logic [TW-1:0]  r_timer, w_timer_nxt;
    logic [W-1:0]   r_a, w_a_nxt;
    logic [W-1:0]   r_n, w_n_nxt;
    rsp_t           r_rsp, w_rsp_nxt;
    logic           r_eng_start, r_rsp_valid, r_busy;

    logic           w_any;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_idx;
    logic [W-1:0]   w_sel_a, w_sel_n;

    // Round-robin search from r_rr_ptr upward; lowest offset wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            w_idx = IDW'((int'(r_rr_ptr) + k) % int'(NREQ));
            if (bus.req_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_sel_a       = bus.req_a[32'(w_win)*W +: W];
    assign w_sel_n       = bus.req_n[32'(w_win)*W +: W];
    assign bus.req_ready = (r_state == S_IDLE && w_any) ? (NREQ'(1) << w_win) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_timer_nxt = r_timer;
        w_a_nxt     = r_a;
        w_n_nxt     = r_n;
        w_rsp_nxt   = r_rsp;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_a_nxt      = w_sel_a;
                    w_n_nxt      = w_sel_n;
                    w_rsp_nxt.id = w_win;
                    // Zero-length job: answer immediately without the engine.
                    if (w_sel_n == '0) begin
                        w_rsp_nxt.sum = '0;
                        w_rsp_nxt.err = 1'b0;
                        w_state_nxt   = S_RESP;
                    end else begin
                        w_state_nxt   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + TW'(1);
                if (bus.eng_done) begin
                    w_rsp_nxt.sum = bus.eng_sum;
                    w_rsp_nxt.err = 1'b0;
                    w_state_nxt   = S_RESP;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_rsp_nxt.sum = '0;
                    w_rsp_nxt.err = 1'b1;
                    w_state_nxt   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_rr_nxt    = IDW'((32'(r_rsp.id) + 32'd1) % NREQ);
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_timer     <= '0;
            r_a         <= '0;
            r_n         <= '0;
            r_rsp       <= '0;
            r_eng_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_timer     <= w_timer_nxt;
            r_a         <= w_a_nxt;
            r_n         <= w_n_nxt;
            r_rsp       <= w_rsp_nxt;
            r_eng_start <= (w_state_nxt == S_ISSUE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.eng_start = r_eng_start;
    assign bus.eng_a     = r_a;
    assign bus.eng_n     = r_n;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp.id;
    assign bus.rsp_sum   = r_rsp.sum;
    assign bus.rsp_err   = r_rsp.err;
    assign bus.busy      = r_busy;
endmodule
